// File: rtl/mul_stall_ctrl_if.sv
// mul_stall_ctrl_if: connection bundle between the decode/ALU side and the
// multiply stall controller. The controller uses the slave modport; whoever
// supplies the decoded request and the multiplier status uses master.
// Optional macro MUL_PERF_CNT_EN adds the MulStallTotal/MulCount counters.
interface mul_stall_ctrl_if #(
  parameter int CW = 6
);

  logic          MulReq;
  logic [3:0]    WA_In;
  logic          Busy;
  logic [31:0]   MResultIn;
  logic          MReset;
  logic          Stall;
  logic          MWrite;
  logic [3:0]    WA_Out;
  logic [31:0]   MResultOut;
  logic          Timeout;
  logic [CW-1:0] CycleCount;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]   MulStallTotal;
  logic [15:0]   MulCount;

  modport slave (
    input  MulReq, WA_In, Busy, MResultIn,
    output MReset, Stall, MWrite, WA_Out, MResultOut, Timeout, CycleCount,
    output MulStallTotal, MulCount
  );

  modport master (
    output MulReq, WA_In, Busy, MResultIn,
    input  MReset, Stall, MWrite, WA_Out, MResultOut, Timeout, CycleCount,
    input  MulStallTotal, MulCount
  );
`else
  modport slave (
    input  MulReq, WA_In, Busy, MResultIn,
    output MReset, Stall, MWrite, WA_Out, MResultOut, Timeout, CycleCount
  );

  modport master (
    output MulReq, WA_In, Busy, MResultIn,
    input  MReset, Stall, MWrite, WA_Out, MResultOut, Timeout, CycleCount
  );
`endif

endinterface

// File: rtl/mul_stall_ctrl.sv
// mul_stall_ctrl: sequences the ALU's iterative multiplier. A decoded multiply
// freezes fetch/decode, the multiplier is released from reset and polled via
// Busy, and the finished product is handed to the register file with a
// one-cycle write strobe. A multiply that never finishes is aborted after
// TIMEOUT cycles in WAIT and signalled with a one-cycle Timeout pulse.
// Optional macro MUL_PERF_CNT_EN adds stall-cycle and multiply counters.
// TIMEOUT must be at least 34 and below 2^CW so the abort compare is reachable.
module mul_stall_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CW      = 6
) (
  input logic              CLK,
  input logic              Reset,
  mul_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          mreset_q;
  logic          stall_q;
  logic          mwrite_q;
  logic          timeout_q;
  logic [3:0]    wa_q;
  logic [31:0]   result_q;
  logic [CW-1:0] cycle_count;
  logic          stall;

  // Stall is registered for START/WAIT, but in IDLE it follows MulReq directly
  // so the PC is already frozen in the cycle the multiply is decoded.
  always_comb begin
    stall = stall_q | ((state == IDLE) & bus.MulReq);
  end

  // Main sequencing FSM; every output except the IDLE stall term is registered
  // and updated together with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      mreset_q    <= 1'b1;
      stall_q     <= 1'b0;
      mwrite_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wa_q        <= '0;
      result_q    <= '0;
      cycle_count <= '0;
    end else begin
      mwrite_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MulReq) begin
            wa_q        <= bus.WA_In;
            cycle_count <= '0;
            stall_q     <= 1'b1;
            mreset_q    <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + CW'(1);
          end
          if (!bus.Busy) begin
            result_q <= bus.MResultIn;
            mwrite_q <= 1'b1;
            stall_q  <= 1'b0;
            mreset_q <= 1'b1;
            state    <= DONE;
          end else if (cycle_count == CW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            stall_q   <= 1'b0;
            mreset_q  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.MReset     = mreset_q;
  assign bus.Stall      = stall;
  assign bus.MWrite     = mwrite_q;
  assign bus.Timeout    = timeout_q;
  assign bus.WA_Out     = wa_q;
  assign bus.MResultOut = result_q;
  assign bus.CycleCount = cycle_count;

`ifdef MUL_PERF_CNT_EN
  logic [31:0] stall_total;
  logic [15:0] mul_count;

  // Performance counters: total frozen cycles and completed (written) multiplies.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_total <= '0;
      mul_count   <= '0;
    end else begin
      if (stall) begin
        stall_total <= stall_total + 32'd1;
      end
      if (mwrite_q) begin
        mul_count <= mul_count + 16'd1;
      end
    end
  end

  assign bus.MulStallTotal = stall_total;
  assign bus.MulCount      = mul_count;
`endif

endmodule

// File: tb/tb_mul_stall_ctrl.sv
// tb_mul_stall_ctrl: self-checking bench for mul_stall_ctrl. A table of
// multiply operations is replayed; each one pushes its expected write-back
// onto a scoreboard that is popped in the DONE cycle. Hand-written sequences
// cover power-on reset, reset in mid-WAIT and (with MUL_PERF_CNT_EN) the
// performance counters.
module tb_mul_stall_ctrl;

  localparam int TIMEOUT = 48;
  localparam int CW      = 6;

  logic CLK = 1'b0;
  logic Reset;

  always #5 CLK = ~CLK;

  mul_stall_ctrl_if #(.CW(CW)) bus ();

  mul_stall_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]    wa;
    logic [31:0]   res;
    logic          timeout;
    logic [CW-1:0] count;
    int            stall_cycles;
  } exp_t;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] res;
    int          busy_waits;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  // Compare one value and log a FAIL line on mismatch.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One quiet IDLE cycle: pipeline free-running, multiplier held in reset.
  task automatic idle_cycle(input string tag);
    bus.MulReq    = 1'b0;
    bus.Busy      = 1'($urandom);
    bus.WA_In     = 4'($urandom);
    bus.MResultIn = $urandom;
    @(negedge CLK);
    check_output({tag, "_stall"},   32'(bus.Stall),   32'd0);
    check_output({tag, "_mreset"},  32'(bus.MReset),  32'd1);
    check_output({tag, "_mwrite"},  32'(bus.MWrite),  32'd0);
    check_output({tag, "_timeout"}, 32'(bus.Timeout), 32'd0);
    next_cycle();
  endtask

  // Run one multiply. busy_waits = WAIT cycles with Busy high before it drops;
  // reset_at >= 0 pulses Reset in that WAIT cycle (0-based) instead of finishing.
  task automatic apply_stimulus(input logic [3:0] wa, input logic [31:0] res,
                                input int busy_waits, input int reset_at);
    exp_t e;
    int   stall_seen;
    bit   did_reset;
    stall_seen = 0;
    did_reset  = 1'b0;
    if (reset_at < 0) begin
      e.wa           = wa;
      e.res          = res;
      e.timeout      = (busy_waits >= TIMEOUT);
      e.count        = e.timeout ? CW'(TIMEOUT) : CW'(busy_waits + 1);
      e.stall_cycles = (e.timeout ? TIMEOUT : busy_waits + 1) + 2;
      sb.push_back(e);
    end

    // IDLE detect cycle
    bus.MulReq    = 1'b1;
    bus.WA_In     = wa;
    bus.Busy      = 1'b0;
    bus.MResultIn = $urandom;
    @(negedge CLK);
    check_output("detect_stall",  32'(bus.Stall),  32'd1);
    check_output("detect_mreset", 32'(bus.MReset), 32'd1);
    stall_seen += int'(bus.Stall);
    next_cycle();

    // START: request, address and Busy are all irrelevant here
    bus.MulReq = 1'($urandom);
    bus.WA_In  = 4'($urandom);
    bus.Busy   = 1'b0;
    @(negedge CLK);
    check_output("start_stall",  32'(bus.Stall),  32'd1);
    check_output("start_mreset", 32'(bus.MReset), 32'd0);
    stall_seen += int'(bus.Stall);
    next_cycle();

    // WAIT: bounded by the abort limit
    for (int w = 0; w < TIMEOUT; w++) begin
      bus.Busy      = (w < busy_waits);
      bus.MResultIn = (w < busy_waits) ? $urandom : res;
      bus.MulReq    = 1'($urandom);
      bus.WA_In     = 4'($urandom);
      if (w == reset_at) Reset = 1'b1;
      @(negedge CLK);
      check_output("wait_stall",  32'(bus.Stall),  32'd1);
      check_output("wait_mreset", 32'(bus.MReset), 32'd0);
      stall_seen += int'(bus.Stall);
      next_cycle();
      if (w == reset_at) begin
        Reset     = 1'b0;
        did_reset = 1'b1;
        break;
      end
      if (!bus.Busy) break;
    end

    bus.MulReq = 1'b0;
    bus.Busy   = 1'b0;
    if (did_reset) begin
      @(negedge CLK);
      check_output("rst_stall",    32'(bus.Stall),      32'd0);
      check_output("rst_mreset",   32'(bus.MReset),     32'd1);
      check_output("rst_mwrite",   32'(bus.MWrite),     32'd0);
      check_output("rst_timeout",  32'(bus.Timeout),    32'd0);
      check_output("rst_count",    32'(bus.CycleCount), 32'd0);
      check_output("rst_wa_out",   32'(bus.WA_Out),     32'd0);
      check_output("rst_result",   32'(bus.MResultOut), 32'd0);
      next_cycle();
      for (int i = 0; i < 3; i++) idle_cycle("post_rst");
    end else begin
      // DONE
      @(negedge CLK);
      check_output("done_stall",  32'(bus.Stall),  32'd0);
      check_output("done_mreset", 32'(bus.MReset), 32'd1);
      if (sb.size() == 0) begin
        check_output("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("stall_cycles", 32'(stall_seen),     32'(e.stall_cycles));
        check_output("done_mwrite",  32'(bus.MWrite),     32'(!e.timeout));
        check_output("done_timeout", 32'(bus.Timeout),    32'(e.timeout));
        check_output("done_count",   32'(bus.CycleCount), 32'(e.count));
        if (!e.timeout) begin
          check_output("done_wa_out", 32'(bus.WA_Out), 32'(e.wa));
          check_output("done_result", bus.MResultOut,  e.res);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    vecs[0] = '{4'd3,  32'd42,         31,  1};  // nominal 34-cycle stall
    vecs[1] = '{4'd1,  32'hFFFF_FFFE,  5,   1};
    vecs[2] = '{4'd2,  32'h0000_0010,  3,   0};  // back-to-back
    vecs[3] = '{4'd15, 32'hA5A5_5A5A,  0,   0};  // minimum 3-cycle stall
    vecs[4] = '{4'd7,  32'h0000_DEAD,  100, 1};  // Busy stuck: abort
    vecs[5] = '{4'd9,  32'h0000_1234,  47,  0};  // Busy drops on the abort cycle
    vecs[6] = '{4'd4,  32'h8000_0001,  10,  2};

    Reset         = 1'b1;
    bus.MulReq    = 1'b0;
    bus.WA_In     = 4'd0;
    bus.Busy      = 1'b0;
    bus.MResultIn = 32'd0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check_output("por_mreset", 32'(bus.MReset),     32'd1);
    check_output("por_stall",  32'(bus.Stall),      32'd0);
    check_output("por_mwrite", 32'(bus.MWrite),     32'd0);
    check_output("por_count",  32'(bus.CycleCount), 32'd0);
    check_output("por_wa_out", 32'(bus.WA_Out),     32'd0);
    check_output("por_result", bus.MResultOut,      32'd0);
    Reset = 1'b0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      idle_cycle("por_idle");
      check_output("por_idle_count", 32'(bus.CycleCount), 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      for (int g = 0; g < vecs[v].gap; g++) idle_cycle("gap");
      apply_stimulus(vecs[v].wa, vecs[v].res, vecs[v].busy_waits, -1);
    end
    idle_cycle("after_table");
    check_output("hold_wa_out", 32'(bus.WA_Out),     32'd4);
    check_output("hold_result", bus.MResultOut,      32'h8000_0001);

    // Reset in the 10th WAIT cycle of a long multiply
    apply_stimulus(4'd6, 32'h1111_1111, 40, 9);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

`ifdef MUL_PERF_CNT_EN
    check_output("perf_clr_total", bus.MulStallTotal,  32'd0);
    check_output("perf_clr_count", 32'(bus.MulCount),  32'd0);
    apply_stimulus(4'd3, 32'd42, 31, -1);
    idle_cycle("perf_gap");
    apply_stimulus(4'd5, 32'd99, 0, -1);
    idle_cycle("perf_end");
    check_output("perf_mul_count",   32'(bus.MulCount), 32'd2);
    check_output("perf_stall_total", bus.MulStallTotal, 32'd37);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
